wb_queue: RTL

WB_QUEUE -- requirements
Module: wb_queue

---
 rtl/wb_queue.sv | 97 +++++++++
 1 files changed

// File: rtl/wb_queue.sv
// rtl/wb_queue.sv - in-order pending register-write queue with newest-match bypass lookup.
// Writes to index 0 complete the handshake but are never stored.
module wb_queue #(
    parameter int ADDR_WIDTH = 5,
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [ADDR_WIDTH-1:0]    in_addr,
    input  logic [DATA_WIDTH-1:0]    in_data,
    input  logic                     stall,
    output logic                     rf_wen,
    output logic [ADDR_WIDTH-1:0]    rf_waddr,
    output logic [DATA_WIDTH-1:0]    rf_wdata,
    input  logic [ADDR_WIDTH-1:0]    byp_addr,
    output logic                     byp_hit,
    output logic [DATA_WIDTH-1:0]    byp_data,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [PTR_W-1:0]      head_q, head_d;
    logic [PTR_W-1:0]      tail_q, tail_d;
    logic [CNT_W-1:0]      count_q, count_d;
    logic [ADDR_WIDTH-1:0] addr_q [DEPTH];
    logic [ADDR_WIDTH-1:0] addr_d [DEPTH];
    logic [DATA_WIDTH-1:0] data_q [DEPTH];
    logic [DATA_WIDTH-1:0] data_d [DEPTH];
    logic                  push;
    logic                  pop;

    assign count    = count_q;
    assign in_ready = !rst && (count_q < CNT_W'(DEPTH));
    assign rf_wen   = !rst && (count_q != '0) && !stall;
    assign rf_waddr = (count_q != '0) ? addr_q[head_q] : '0;
    assign rf_wdata = (count_q != '0) ? data_q[head_q] : '0;
    assign push     = in_valid && in_ready && (in_addr != '0);
    assign pop      = rf_wen;

    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        addr_d  = addr_q;
        data_d  = data_q;
        if (push) begin
            addr_d[tail_q] = in_addr;
            data_d[tail_q] = in_data;
            tail_d         = tail_q + PTR_W'(1);
        end
        if (pop) begin
            head_d = head_q + PTR_W'(1);
        end
        case ({push, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    // Walk oldest to newest so a later match overrides an earlier one.
    always_comb begin
        byp_hit  = 1'b0;
        byp_data = '0;
        if (byp_addr != '0) begin
            for (int i = 0; i < DEPTH; i++) begin
                if ((CNT_W'(i) < count_q) && (addr_q[head_q + PTR_W'(i)] == byp_addr)) begin
                    byp_hit  = 1'b1;
                    byp_data = data_q[head_q + PTR_W'(i)];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        addr_q <= addr_d;
        data_q <= data_d;
    end

endmodule
